reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
8-entry x 8-bit register file that sits directly upstream of the ALU. It supplies DATA1/DATA2 through two read ports and takes RESULT back through one write port. It carries a per-register pending scoreboard, so issue logic can stall when an operand's producer has not yet written back. It is the storage stage of the single-cycle datapath.

Parameters:
DATA_W, 8, register and data width (matches ALU DATA1/DATA2/RESULT)
ADDR_W, 3, register address width; depth = 2**ADDR_W = 8
BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads see array contents only

Ports:
CLK  in  1  clock; all state updates on rising edge
RESETN  in  1  asynchronous active-low reset
WRITEDATA  in  DATA_W  write-back data (ALU RESULT)
WRITEREG  in  ADDR_W  write-back destination register
WRITEENABLE  in  1  write strobe, sampled at rising CLK
READREG1  in  ADDR_W  read port 1 address
READREG2  in  ADDR_W  read port 2 address
REGOUT1  out  DATA_W  read port 1 data (to ALU DATA1)
REGOUT2  out  DATA_W  read port 2 data (to ALU DATA2)
ISSUE  in  1  instruction issued with destination ISSUEREG; marks it pending
ISSUEREG  in  ADDR_W  destination of issued instruction
PENDING1  out  1  READREG1 awaiting write-back
PENDING2  out  1  READREG2 awaiting write-back
STALL  out  1  PENDING1 | PENDING2
PEND_CNT  out  ADDR_W+1  number of registers currently pending (0..8)

Behaviour:
- Reset: RESETN low clears all 8 registers to 0, all pending bits to 0 and PEND_CNT to 0 immediately, independent of CLK. REGOUT1/2=0, PENDING1/2=0, STALL=0 while reset is held. Reset asserted mid-write discards that write.
- Storage: all 8 registers are writable; register 0 is not hardwired.
- Write: at rising CLK with WRITEENABLE=1, reg[WRITEREG] <= WRITEDATA and pending[WRITEREG] <= 0. With WRITEENABLE=0 the array holds.
- Read: combinational, zero-cycle latency. REGOUTx = reg[READREGx].
- Bypass (BYPASS=1): if WRITEENABLE=1 and WRITEREG==READREGx, then REGOUTx=WRITEDATA and PENDINGx=0 in the same cycle. Both ports may bypass at once.
- BYPASS=0: REGOUTx shows the new value only from the cycle after the edge. PENDINGx reflects the registered pending bit only.
- Issue: at rising CLK with ISSUE=1, pending[ISSUEREG] <= 1.
- Simultaneous ISSUE and WRITEENABLE to the same register: set wins. The data is written, and the register stays pending because it has a new producer.
- Simultaneous ISSUE and WRITEENABLE to different registers: both take effect.
- ISSUE to an already-pending register: no change, no error. WRITEENABLE to a non-pending register: normal write, pending stays 0.
- PEND_CNT: registered count of pending bits, updated each edge.
  - +1 when a clear bit is set.
  - -1 when a set bit is cleared.
  - Net 0 for a same-register issue+write on a pending register.
  - Never wraps: 8 is the maximum, 0 the minimum by construction.
- STALL is purely combinational from PENDING1/2; the block applies no write-enable gating on STALL.
- No X propagation: all addresses are in range, so every address decodes.

Test Plan:
1. Reset: drive RESETN=0 mid-cycle after writing 8'hA5 to r3 -> REGOUT1 (READREG1=3) = 8'h00 immediately, PEND_CNT=0.
2. Write/read: write r2=8'h82, r5=8'hC6 on consecutive edges; READREG1=2, READREG2=5 -> REGOUT1=8'h82, REGOUT2=8'hC6; all 8 registers written with distinct values and read back correctly.
3. Bypass: BYPASS=1, WRITEENABLE=1, WRITEREG=4, WRITEDATA=8'h3C, READREG1=READREG2=4 before the edge -> both REGOUT=8'h3C in the same cycle. BYPASS=0 instance -> old value until after the edge.
4. Scoreboard: ISSUE r6 -> next cycle PENDING1=1 (READREG1=6), STALL=1, PEND_CNT=1. Write r6=8'h11 -> after the edge PENDING1=0, STALL=0, PEND_CNT=0, REGOUT1=8'h11.
5. Collision: r1 pending; same edge ISSUE r1 and WRITEENABLE r1 = 8'h90 -> REGOUT1=8'h90, PENDING1 still 1, PEND_CNT unchanged at 1.
6. Count limits: ISSUE r0..r7 on 8 edges -> PEND_CNT=8. Re-issue r3 -> stays 8. Write all 8 -> PEND_CNT returns to 0.

Source files
------------

// File: rtl/reg_file_sb.sv
// 8x8 register file feeding the ALU, with a per-register pending scoreboard.
// Two combinational read ports, one write-back port, optional write bypass.
module reg_file_sb #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter bit BYPASS = 1'b1
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [DATA_W-1:0] WRITEDATA,
    input  logic [ADDR_W-1:0] WRITEREG,
    input  logic              WRITEENABLE,
    input  logic [ADDR_W-1:0] READREG1,
    input  logic [ADDR_W-1:0] READREG2,
    output logic [DATA_W-1:0] REGOUT1,
    output logic [DATA_W-1:0] REGOUT2,
    input  logic              ISSUE,
    input  logic [ADDR_W-1:0] ISSUEREG,
    output logic              PENDING1,
    output logic              PENDING2,
    output logic              STALL,
    output logic [ADDR_W:0]   PEND_CNT
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;

    logic              byp_en;
    logic              hit1;
    logic              hit2;

    // Issue is applied after write-back so a same-register collision stays pending.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (WRITEENABLE) begin
            regs_d[WRITEREG] = WRITEDATA;
            pend_d[WRITEREG] = 1'b0;
        end
        if (ISSUE) begin
            pend_d[ISSUEREG] = 1'b1;
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // Forwarding is masked during reset so outputs read as zero.
    assign byp_en = BYPASS && RESETN && WRITEENABLE;
    assign hit1   = byp_en && (WRITEREG == READREG1);
    assign hit2   = byp_en && (WRITEREG == READREG2);

    assign REGOUT1  = hit1 ? WRITEDATA : regs_q[READREG1];
    assign REGOUT2  = hit2 ? WRITEDATA : regs_q[READREG2];
    assign PENDING1 = pend_q[READREG1] & ~hit1;
    assign PENDING2 = pend_q[READREG2] & ~hit2;
    assign STALL    = PENDING1 | PENDING2;
    assign PEND_CNT = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb, exercising bypass and non-bypass instances.
module tb_reg_file_sb;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic [7:0] WRITEDATA;
    logic [2:0] WRITEREG;
    logic       WRITEENABLE;
    logic [2:0] READREG1;
    logic [2:0] READREG2;
    logic       ISSUE;
    logic [2:0] ISSUEREG;

    logic [7:0] b1_o1, b1_o2, b0_o1, b0_o2;
    logic       b1_p1, b1_p2, b1_st, b0_p1, b0_p2, b0_st;
    logic [3:0] b1_cnt, b0_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    reg_file_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b1)) u_b1 (
        .CLK(CLK), .RESETN(RESETN),
        .WRITEDATA(WRITEDATA), .WRITEREG(WRITEREG), .WRITEENABLE(WRITEENABLE),
        .READREG1(READREG1), .READREG2(READREG2),
        .REGOUT1(b1_o1), .REGOUT2(b1_o2),
        .ISSUE(ISSUE), .ISSUEREG(ISSUEREG),
        .PENDING1(b1_p1), .PENDING2(b1_p2), .STALL(b1_st), .PEND_CNT(b1_cnt)
    );

    reg_file_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b0)) u_b0 (
        .CLK(CLK), .RESETN(RESETN),
        .WRITEDATA(WRITEDATA), .WRITEREG(WRITEREG), .WRITEENABLE(WRITEENABLE),
        .READREG1(READREG1), .READREG2(READREG2),
        .REGOUT1(b0_o1), .REGOUT2(b0_o2),
        .ISSUE(ISSUE), .ISSUEREG(ISSUEREG),
        .PENDING1(b0_p1), .PENDING2(b0_p2), .STALL(b0_st), .PEND_CNT(b0_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        RESETN = 1'b0; WRITEDATA = '0; WRITEREG = '0; WRITEENABLE = 1'b0;
        READREG1 = '0; READREG2 = '0; ISSUE = 1'b0; ISSUEREG = '0;
        #12;
        check("rst_out1", b1_o1, 0);
        check("rst_cnt", b1_cnt, 0);
        check("rst_stall", b1_st, 0);
        RESETN = 1'b1;
        tick();

        // reset mid-write
        WRITEENABLE = 1; WRITEREG = 3; WRITEDATA = 8'hA5;
        tick();
        WRITEENABLE = 0; READREG1 = 3;
        #1 check("wr_r3", b0_o1, 8'hA5);
        WRITEENABLE = 1; WRITEDATA = 8'h77; ISSUE = 1; ISSUEREG = 3;
        #1 RESETN = 1'b0;
        #1 check("rst_async_b1", b1_o1, 0);
        check("rst_async_b0", b0_o1, 0);
        check("rst_async_pend", b1_p1, 0);
        check("rst_async_cnt", b0_cnt, 0);
        tick();
        RESETN = 1'b1; WRITEENABLE = 0; ISSUE = 0;
        #1 check("rst_discard", b0_o1, 0);
        check("rst_discard_cnt", b0_cnt, 0);

        // write/read
        WRITEENABLE = 1; WRITEREG = 2; WRITEDATA = 8'h82;
        tick();
        WRITEREG = 5; WRITEDATA = 8'hC6;
        tick();
        WRITEENABLE = 0; READREG1 = 2; READREG2 = 5;
        #1 check("rd_r2", b0_o1, 8'h82);
        check("rd_r5", b0_o2, 8'hC6);
        for (int i = 0; i < 8; i++) begin
            WRITEENABLE = 1; WRITEREG = 3'(i); WRITEDATA = 8'(i * 17 + 3);
            tick();
        end
        WRITEENABLE = 0;
        for (int i = 0; i < 8; i++) begin
            READREG1 = 3'(i); READREG2 = 3'(7 - i);
            #1 check("rd_all_p1", b0_o1, 8'(i * 17 + 3));
            check("rd_all_p2", b1_o2, 8'((7 - i) * 17 + 3));
        end

        // bypass
        WRITEENABLE = 1; WRITEREG = 4; WRITEDATA = 8'h3C;
        READREG1 = 4; READREG2 = 4;
        #1 check("byp_p1", b1_o1, 8'h3C);
        check("byp_p2", b1_o2, 8'h3C);
        check("nobyp_old", b0_o1, 8'h47);
        tick();
        WRITEENABLE = 0;
        #1 check("nobyp_new", b0_o1, 8'h3C);
        check("nobyp_new2", b0_o2, 8'h3C);

        // scoreboard
        ISSUE = 1; ISSUEREG = 6;
        tick();
        ISSUE = 0; READREG1 = 6; READREG2 = 0;
        #1 check("sb_pend1", b1_p1, 1);
        check("sb_stall", b1_st, 1);
        check("sb_cnt1", b1_cnt, 1);
        check("sb_pend2_clr", b1_p2, 0);
        WRITEENABLE = 1; WRITEREG = 6; WRITEDATA = 8'h11;
        #1 check("sb_byp_pend", b1_p1, 0);
        check("sb_byp_stall", b1_st, 0);
        check("sb_nobyp_pend", b0_p1, 1);
        tick();
        WRITEENABLE = 0;
        #1 check("sb_wb_pend", b0_p1, 0);
        check("sb_wb_stall", b0_st, 0);
        check("sb_wb_cnt", b0_cnt, 0);
        check("sb_wb_data", b0_o1, 8'h11);

        // collision
        ISSUE = 1; ISSUEREG = 1;
        tick();
        WRITEENABLE = 1; WRITEREG = 1; WRITEDATA = 8'h90;
        tick();
        ISSUE = 0; WRITEENABLE = 0; READREG1 = 1;
        #1 check("col_data", b0_o1, 8'h90);
        check("col_pend", b1_p1, 1);
        check("col_cnt", b1_cnt, 1);
        WRITEENABLE = 1; WRITEDATA = 8'h91;
        tick();
        WRITEENABLE = 0;
        #1 check("col_clr_cnt", b0_cnt, 0);

        // count limits
        for (int i = 0; i < 8; i++) begin
            ISSUE = 1; ISSUEREG = 3'(i);
            tick();
        end
        ISSUE = 0;
        #1 check("cnt_full", b0_cnt, 8);
        ISSUE = 1; ISSUEREG = 3;
        tick();
        ISSUE = 0;
        #1 check("cnt_reissue", b1_cnt, 8);
        for (int i = 0; i < 8; i++) begin
            WRITEENABLE = 1; WRITEREG = 3'(i); WRITEDATA = 8'(8'hF0 + i);
            tick();
            if (i == 3) check("cnt_half", b0_cnt, 4);
        end
        WRITEENABLE = 0;
        #1 check("cnt_empty", b0_cnt, 0);
        READREG1 = 7;
        v = b0_o1;
        check("cnt_lastdata", v, 8'hF7);

        // issue and write to different registers
        ISSUE = 1; ISSUEREG = 2;
        WRITEENABLE = 1; WRITEREG = 5; WRITEDATA = 8'h5A;
        tick();
        ISSUE = 0; WRITEENABLE = 0; READREG1 = 2; READREG2 = 5;
        #1 check("diff_pend1", b0_p1, 1);
        check("diff_pend2", b0_p2, 0);
        check("diff_data", b0_o2, 8'h5A);
        check("diff_cnt", b0_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
